bcd_scan_counter: RTL and testbench
===================================

# bcd_scan_counter

Multi-digit BCD up/down counter with a built-in display scanner. It sits directly upstream of the BCD-to-7-segment decoder. It produces a prescaled decimal count, then time-multiplexes the digits onto one 4-bit BCD nibble plus a one-hot digit select. The decoder's 4-bit input is driven from `scan_bcd`.

## Interface
Parameters:
- `DIGITS`, 4: number of BCD digits, 1..8.
- `PRESCALE`, 50_000_000: clock cycles per count step, ≥ 1.
- `SCAN_DIV`, 50_000: clock cycles per scanned digit, ≥ 1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: count enable; prescaler advances only while high.
- `up`, in, 1: 1 = count up, 0 = count down; sampled on the step cycle.
- `load`, in, 1: synchronous load strobe.
- `load_val`, in, 4*DIGITS: value to load; digit 0 in bits [3:0].
- `bcd`, out, 4*DIGITS: registered count.
- `wrap`, out, 1: one-cycle pulse on overflow/underflow of the full count.
- `err`, out, 1: one-cycle pulse on a rejected load.
- `scan_sel`, out, DIGITS: one-hot, active-high digit select.
- `scan_bcd`, out, 4: nibble of `bcd` selected by `scan_sel`; feeds the 7-segment decoder.

## Operation
- Priority per cycle: `rst` > `load` > count step.
- Prescaler:
  - 0..PRESCALE-1, increments when `en`=1, holds when `en`=0.
  - Cleared by `rst` and by any `load`, accepted or rejected.
  - Step fires on the cycle it equals PRESCALE-1 with `en`=1; it then returns to 0.
- Count step up:
  - Digit 0 +1.
  - A digit at 9 becomes 0 and carries into the next digit.
  - All digits 9 → all 0, `wrap`=1.
- Count step down:
  - Digit 0 −1.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - All 0 → all 9, `wrap`=1.
- Load:
  - All nibbles ≤ 9: `bcd`←`load_val`.
  - Any nibble > 9: `bcd` unchanged, `err`=1 for one cycle.
- Scanner:
  - Independent divider 0..SCAN_DIV-1, runs regardless of `en`.
  - At terminal count, the index advances modulo DIGITS.
  - `scan_sel` = 1<<index.
  - `scan_bcd` = `bcd[4*index+:4]`, combinational from registered index and `bcd`.
  - Scanner is unaffected by `load`.
- `bcd` never holds a nibble > 9.

## Timing
- Reset values:
  - `bcd`=0, `wrap`=0, `err`=0.
  - Prescaler 0, scan divider 0, index 0.
  - `scan_sel`=…0001, `scan_bcd`=0.
- Step latency: `bcd` changes on the clock edge ending the step cycle. `wrap` is asserted in the same cycle as the new value.
- Load latency: `bcd` holds `load_val` one cycle after the `load` cycle. `err` is asserted in that same cycle.
- A step coinciding with `load` is discarded; the next step comes PRESCALE enabled cycles after the load.
- `up` changing between steps takes effect at the next step only.
- A `load` asserted for N cycles reloads N times; the prescaler stays at 0 throughout.
- Reset mid-count or mid-scan: everything returns to reset values on the next edge; no partial step.
- Scan: each digit is selected for exactly SCAN_DIV cycles. `scan_bcd` reflects a count change in the same cycle `bcd` changes.
- `wrap` and `err` are never both 1 in the same cycle.

## Configuration
- `BCD_CNT_SATURATE_EN`, defined:
  - Up at all-9 holds at all-9; down at all-0 holds at 0.
  - `wrap` still pulses, flagging the attempted overflow.
  - Digits below the top wrap normally.
- Not defined: full wrap-around as described in Operation.

## Structure
- Package `bcd_pkg`:
  - `BCD_MAX` = 4'd9, `BCD_MIN` = 4'd0.
  - Nibble-validity function `bcd_valid`.
  - Digit-width constant `BCD_W` = 4.
- Sub-module `bcd_digit`:
  - One-digit up/down cell.
  - Inputs: `step`, `up`, `cin`. Outputs: `digit`, `cout` (carry/borrow out at 9→0 or 0→9).
  - Instantiated DIGITS times in a generate chain.
  - The top level holds load, prescaler, scanner, saturation and `err`/`wrap`.

## Test plan
Bench uses PRESCALE=4, SCAN_DIV=3, DIGITS=4.
- Reset, `en`=1, `up`=1 for 40 cycles → `bcd` 0000→0010, one step every 4 cycles, `wrap` never set.
- Load 9998, then up for 2 steps:
  - Wrap build → 9999 then 0000 with `wrap`=1 for exactly one cycle.
  - With `BCD_CNT_SATURATE_EN` → holds 9999, `wrap` pulses.
- Load 0000, `up`=0, 1 step → 9999, `wrap`=1; load 0100, 1 step down → 0099.
- Load 12A4 (nibble 0xA) → `err`=1 one cycle, `bcd` unchanged, prescaler restarts at 0.
- `load` and step in the same cycle → loaded value wins, no step applied.
- Scanner:
  - `bcd`=4321 → `scan_sel`/`scan_bcd` cycle 0001/1, 0010/2, 0100/3, 1000/4, each for 3 cycles, then repeat.
  - `rst` mid-scan → `scan_sel`=0001 and `bcd`=0 on the next edge.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, types and helpers for the BCD scan counter.
//   BCD_W      - width of one BCD digit
//   BCD_MAX    - largest legal digit value (9)
//   BCD_MIN    - smallest legal digit value (0)
//   bcd_digit_t- one BCD nibble
//   bcd_valid  - returns 1 when a nibble holds a legal BCD digit
package bcd_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic bcd_valid(input bcd_digit_t nib);
    return (nib <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD up/down counter cell, chained through cin/cout.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset, digit returns to 0
//   step       - count step for the whole chain this cycle
//   up         - 1 = count up, 0 = count down
//   cin        - carry/borrow from the lower digit (tie 1 for digit 0)
//   load       - load load_digit (already validated by the parent)
//   load_digit - value to load
//   digit      - registered digit value
//   cout       - carry/borrow to the next digit: cin while at 9 (up) or 0 (down)
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       cin,
  input  logic       load,
  input  bcd_digit_t load_digit,
  output bcd_digit_t digit,
  output logic       cout
);

  bcd_digit_t digit_q, digit_d;
  logic       at_edge;

  // Digit sits at the value that rolls over in the current direction.
  assign at_edge = up ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);
  // Carry depends only on state, not on step, so the parent can use the
  // top carry to decide saturation before committing a step.
  assign cout    = cin & at_edge;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_digit;
    end else if (step && cin) begin
      if (up) begin
        digit_d = at_edge ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = at_edge ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

endmodule

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: prescaled multi-digit BCD up/down counter with a
// time-multiplexed digit scanner feeding a BCD-to-7-segment decoder.
// Parameters:
//   DIGITS   - number of BCD digits (1..8)
//   PRESCALE - enabled clock cycles per count step (>= 1)
//   SCAN_DIV - clock cycles each digit stays selected (>= 1)
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   en       - count enable, gates the prescaler
//   up       - count direction, sampled on the step cycle
//   load     - synchronous load strobe (wins over a step)
//   load_val - value to load, digit 0 in bits [3:0]
//   bcd      - registered count
//   wrap     - one-cycle pulse on overflow/underflow of the full count
//   err      - one-cycle pulse when a load carried a nibble > 9
//   scan_sel - one-hot active-high digit select
//   scan_bcd - nibble of bcd picked by scan_sel
// Build option:
//   BCD_CNT_SATURATE_EN - when defined, the count holds at all-9 (up) or
//   all-0 (down) instead of wrapping; wrap still pulses on the attempt.
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 50_000_000,
  parameter int unsigned SCAN_DIV = 50_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    wrap,
  output logic                    err,
  output logic [DIGITS-1:0]       scan_sel,
  output logic [BCD_W-1:0]        scan_bcd
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // ---------------------------------------------------------------------
  // Load validation
  // ---------------------------------------------------------------------
  logic load_ok;
  logic load_accept;

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_valid(load_val[i*BCD_W +: BCD_W])) begin
        load_ok = 1'b0;
      end
    end
  end

  assign load_accept = load & load_ok;

  // ---------------------------------------------------------------------
  // Prescaler: cleared by any load, so a step never coincides with a load
  // ---------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic          presc_last;
  logic          step_raw;

  assign presc_last = (presc_q == PW'(PRESCALE - 1));
  assign step_raw   = en & presc_last & ~load;

  always_comb begin
    presc_d = presc_q;
    if (load) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = presc_last ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // ---------------------------------------------------------------------
  // Digit chain
  // ---------------------------------------------------------------------
  logic [DIGITS:0] carry;
  logic            full_carry;
  logic            step_cells;

  assign carry[0]   = 1'b1;
  // All digits at the rollover value for the current direction.
  assign full_carry = carry[DIGITS];

`ifdef BCD_CNT_SATURATE_EN
  // Suppress the step entirely at the rail; lower digits would otherwise
  // roll over even though the top cannot.
  assign step_cells = step_raw & ~full_carry;
`else
  assign step_cells = step_raw;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .step       (step_cells),
      .up         (up),
      .cin        (carry[g]),
      .load       (load_accept),
      .load_digit (load_val[g*BCD_W +: BCD_W]),
      .digit      (bcd[g*BCD_W +: BCD_W]),
      .cout       (carry[g+1])
    );
  end

  // ---------------------------------------------------------------------
  // Status pulses. step_raw excludes load, so wrap and err are exclusive.
  // ---------------------------------------------------------------------
  logic wrap_q, wrap_d;
  logic err_q, err_d;

  always_comb begin
    wrap_d = step_raw & full_carry;
    err_d  = load & ~load_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign wrap = wrap_q;
  assign err  = err_q;

  // ---------------------------------------------------------------------
  // Scanner: free-running, independent of en and load
  // ---------------------------------------------------------------------
  logic [SW-1:0] div_q, div_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          div_last;

  assign div_last = (div_q == SW'(SCAN_DIV - 1));

  always_comb begin
    div_d = div_last ? '0 : div_q + SW'(1);
    idx_d = idx_q;
    if (div_last) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  // Combinational from registered index and count, so a count change is
  // visible on scan_bcd in the same cycle as on bcd.
  always_comb begin
    scan_sel = '0;
    scan_bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        scan_sel[i] = 1'b1;
        scan_bcd    = bcd[i*BCD_W +: BCD_W];
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter (DIGITS=4, PRESCALE=4, SCAN_DIV=3).
// A decimal-arithmetic reference model predicts every cycle; predictions are
// queued when stimulus is driven and compared once the DUT edge has passed.
// A phase table adds hand-computed end-of-phase values and pulse counts.
module tb_bcd_scan_counter;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int SCAN_DIV = 3;

  logic        clk = 1'b0;
  logic        rst, en, up, load;
  logic [15:0] load_val;
  logic [15:0] bcd;
  logic        wrap, err;
  logic [3:0]  scan_sel;
  logic [3:0]  scan_bcd;

  bcd_scan_counter #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .bcd      (bcd),
    .wrap     (wrap),
    .err      (err),
    .scan_sel (scan_sel),
    .scan_bcd (scan_bcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic        wrap;
    logic        err;
    logic [3:0]  sel;
    logic [3:0]  sbcd;
  } exp_t;

  typedef struct {
    string       name;
    bit          r, e, u, l;
    logic [15:0] lv;
    int          n;
    logic [15:0] end_bcd;
    int          wraps;
    int          errs;
  } vec_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   wrap_seen, err_seen;

  // Reference model state (decimal value, not digits)
  int m_val = 0, m_pre = 0, m_div = 0, m_idx = 0;
  bit m_wrap = 0, m_err = 0;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic bit nib_ok(input logic [15:0] v);
    for (int i = 0; i < DIGITS; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int from_bcd(input logic [15:0] v);
    int r = 0;
    for (int i = 0; i < DIGITS; i++) r = r + int'(v[i*4 +: 4]) * pow10(i);
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit u, input bit l,
                            input logic [15:0] lv);
    int max_val = pow10(DIGITS) - 1;
    if (r) begin
      m_val = 0; m_pre = 0; m_div = 0; m_idx = 0; m_wrap = 0; m_err = 0;
    end else begin
      m_wrap = 0;
      m_err  = 0;
      if (m_div == SCAN_DIV - 1) begin
        m_div = 0;
        m_idx = (m_idx + 1) % DIGITS;
      end else begin
        m_div++;
      end
      if (l) begin
        m_pre = 0;
        if (nib_ok(lv)) m_val = from_bcd(lv);
        else m_err = 1;
      end else if (e) begin
        if (m_pre == PRESCALE - 1) begin
          m_pre = 0;
          if (u) begin
            if (m_val == max_val) begin
              m_wrap = 1;
`ifndef BCD_CNT_SATURATE_EN
              m_val = 0;
`endif
            end else begin
              m_val++;
            end
          end else begin
            if (m_val == 0) begin
              m_wrap = 1;
`ifndef BCD_CNT_SATURATE_EN
              m_val = max_val;
`endif
            end else begin
              m_val--;
            end
          end
        end else begin
          m_pre++;
        end
      end
    end
  endtask

  // One clock: drive inputs, queue the prediction, then compare after the edge.
  task automatic tick(input bit r, input bit e, input bit u, input bit l,
                      input logic [15:0] lv);
    exp_t x;
    rst = r; en = e; up = u; load = l; load_val = lv;
    model_step(r, e, u, l, lv);
    x.bcd  = to_bcd(m_val);
    x.wrap = m_wrap;
    x.err  = m_err;
    x.sel  = 4'(1 << m_idx);
    x.sbcd = 4'((m_val / pow10(m_idx)) % 10);
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check("bcd", bcd, x.bcd);
    check("wrap", 16'(wrap), 16'(x.wrap));
    check("err", 16'(err), 16'(x.err));
    check("scan_sel", 16'(scan_sel), 16'(x.sel));
    check("scan_bcd", 16'(scan_bcd), 16'(x.sbcd));
    if (wrap === 1'b1) wrap_seen++;
    if (err === 1'b1) err_seen++;
  endtask

  vec_t vt[26];

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;

    //          name          r  e  u  l  lv        n   end       wraps errs
    vt[0]  = '{"reset",       1, 0, 1, 0, 16'h0000, 2,  16'h0000, 0, 0};
    vt[1]  = '{"count_up",    0, 1, 1, 0, 16'h0000, 40, 16'h0010, 0, 0};
    vt[2]  = '{"load_9998",   0, 0, 1, 1, 16'h9998, 1,  16'h9998, 0, 0};
`ifdef BCD_CNT_SATURATE_EN
    vt[3]  = '{"up_top",      0, 1, 1, 0, 16'h0000, 8,  16'h9999, 1, 0};
`else
    vt[3]  = '{"up_top",      0, 1, 1, 0, 16'h0000, 8,  16'h0000, 1, 0};
`endif
    vt[4]  = '{"load_0000",   0, 0, 0, 1, 16'h0000, 1,  16'h0000, 0, 0};
`ifdef BCD_CNT_SATURATE_EN
    vt[5]  = '{"down_bottom", 0, 1, 0, 0, 16'h0000, 4,  16'h0000, 1, 0};
`else
    vt[5]  = '{"down_bottom", 0, 1, 0, 0, 16'h0000, 4,  16'h9999, 1, 0};
`endif
    vt[6]  = '{"load_0100",   0, 0, 0, 1, 16'h0100, 1,  16'h0100, 0, 0};
    vt[7]  = '{"down_borrow", 0, 1, 0, 0, 16'h0000, 4,  16'h0099, 0, 0};
    vt[8]  = '{"partial",     0, 1, 0, 0, 16'h0000, 2,  16'h0099, 0, 0};
    vt[9]  = '{"bad_load",    0, 1, 0, 1, 16'h12a4, 1,  16'h0099, 0, 1};
    vt[10] = '{"presc_clr",   0, 1, 1, 0, 16'h0000, 3,  16'h0099, 0, 0};
    vt[11] = '{"step_after",  0, 1, 1, 0, 16'h0000, 1,  16'h0100, 0, 0};
    vt[12] = '{"arm_step",    0, 1, 1, 0, 16'h0000, 3,  16'h0100, 0, 0};
    vt[13] = '{"load_vs_step",0, 1, 1, 1, 16'h0500, 1,  16'h0500, 0, 0};
    vt[14] = '{"after_load",  0, 1, 1, 0, 16'h0000, 3,  16'h0500, 0, 0};
    vt[15] = '{"next_step",   0, 1, 1, 0, 16'h0000, 1,  16'h0501, 0, 0};
    vt[16] = '{"en_low",      0, 0, 1, 0, 16'h0000, 5,  16'h0501, 0, 0};
    vt[17] = '{"load_held",   0, 1, 1, 1, 16'h0777, 3,  16'h0777, 0, 0};
    vt[18] = '{"held_after",  0, 1, 1, 0, 16'h0000, 3,  16'h0777, 0, 0};
    vt[19] = '{"held_step",   0, 1, 1, 0, 16'h0000, 1,  16'h0778, 0, 0};
    vt[20] = '{"dir_down",    0, 1, 0, 0, 16'h0000, 2,  16'h0778, 0, 0};
    vt[21] = '{"dir_up",      0, 1, 1, 0, 16'h0000, 2,  16'h0779, 0, 0};
    vt[22] = '{"pre_rst",     0, 1, 1, 0, 16'h0000, 2,  16'h0779, 0, 0};
    vt[23] = '{"rst_mid",     1, 1, 1, 0, 16'h0000, 1,  16'h0000, 0, 0};
    vt[24] = '{"no_partial",  0, 1, 1, 0, 16'h0000, 3,  16'h0000, 0, 0};
    vt[25] = '{"first_step",  0, 1, 1, 0, 16'h0000, 1,  16'h0001, 0, 0};

    for (int v = 0; v < 26; v++) begin
      wrap_seen = 0;
      err_seen  = 0;
      for (int c = 0; c < vt[v].n; c++) begin
        tick(vt[v].r, vt[v].e, vt[v].u, vt[v].l, vt[v].lv);
      end
      check({vt[v].name, "_end_bcd"}, bcd, vt[v].end_bcd);
      check({vt[v].name, "_wraps"}, 16'(wrap_seen), 16'(vt[v].wraps));
      check({vt[v].name, "_errs"}, 16'(err_seen), 16'(vt[v].errs));
    end

    // Scanner walk: after reset the index advances every SCAN_DIV edges.
    tick(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    check("scan_rst_sel", 16'(scan_sel), 16'h0001);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 16'h4321);
    for (int k = 2; k < 26; k++) begin
      int idx;
      tick(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      idx = (k / SCAN_DIV) % DIGITS;
      check("scan_walk_sel", 16'(scan_sel), 16'(1 << idx));
      check("scan_walk_bcd", 16'(scan_bcd), 16'(idx + 1));
    end

    // Reset in the middle of a digit's dwell.
    tick(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    check("scan_rst_mid_sel", 16'(scan_sel), 16'h0001);
    check("scan_rst_mid_bcd", bcd, 16'h0000);
    check("scan_rst_mid_nib", 16'(scan_bcd), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
